// File: rtl/bpsk_frame_sync.sv
// BPSK frame synchronizer: hunts for the sync word in either polarity, reads a length
// byte, packs payload bits MSB-first into bytes and queues them behind valid/ready.
module bpsk_frame_sync #(
    parameter int                   SYNC_BITS  = 16,
    parameter logic [SYNC_BITS-1:0] SYNC_WORD  = 16'hD391,
    parameter int                   FIFO_DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       bit_in,
    input  logic       bit_toggle,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic       frame_active,
    output logic       polarity_inv,
    output logic       frame_done,
    output logic       overflow
);
    localparam int             PW       = $clog2(FIFO_DEPTH);
    localparam logic [PW:0]    FULL_CNT = (PW+1)'(FIFO_DEPTH);
    localparam logic [PW:0]    CNT_ONE  = (PW+1)'(1);
    localparam logic [PW-1:0]  PTR_ONE  = PW'(1);

    typedef enum logic [1:0] {HUNT, LENGTH, PAYLOAD} state_t;

    state_t               state, state_nx;
    logic                 toggle_q;
    logic                 bit_ev;
    logic                 eb;
    logic [SYNC_BITS-1:0] shreg, shreg_nx;
    logic [2:0]           bitcnt;
    logic [7:0]           acc, acc_nx;
    logic [7:0]           left, left_nx;
    logic                 pol_nx;
    logic                 push;
    logic                 done_nx;

    logic [7:0]           mem [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic [PW:0]          count;
    logic                 accept;
    logic                 pop;

    always_comb begin
        bit_ev   = bit_toggle ^ toggle_q;
        eb       = bit_in ^ polarity_inv;
        shreg_nx = (shreg << 1) | {{(SYNC_BITS-1){1'b0}}, bit_in};
        acc_nx   = (acc << 1) | {7'd0, eb};
        state_nx = state;
        pol_nx   = polarity_inv;
        left_nx  = left;
        push     = 1'b0;
        done_nx  = 1'b0;
        if (bit_ev) begin
            case (state)
                HUNT: begin
                    // Both polarities are tested against the register including the new bit.
                    if (shreg_nx == SYNC_WORD) begin
                        state_nx = LENGTH;
                        pol_nx   = 1'b0;
                    end else if (shreg_nx == ~SYNC_WORD) begin
                        state_nx = LENGTH;
                        pol_nx   = 1'b1;
                    end
                end
                LENGTH: begin
                    if (bitcnt == 3'd7) begin
                        if (acc_nx == 8'd0) begin
                            state_nx = HUNT;
                            pol_nx   = 1'b0;
                            done_nx  = 1'b1;
                        end else begin
                            state_nx = PAYLOAD;
                            left_nx  = acc_nx;
                        end
                    end
                end
                PAYLOAD: begin
                    if (bitcnt == 3'd7) begin
                        push    = 1'b1;
                        left_nx = left - 8'd1;
                        if (left == 8'd1) begin
                            state_nx = HUNT;
                            pol_nx   = 1'b0;
                            done_nx  = 1'b1;
                        end
                    end
                end
                default: state_nx = HUNT;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) state <= HUNT;
        else       state <= state_nx;
    end

    // A full FIFO at the start of the cycle rejects the push even if a pop happens too.
    assign accept = push && (count < FULL_CNT);
    assign pop    = byte_valid && byte_ready;

    always_ff @(posedge clock) begin
        toggle_q <= bit_toggle;
        if (reset) begin
            polarity_inv <= 1'b0;
            shreg        <= '0;
            bitcnt       <= 3'd0;
            left         <= 8'd0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            frame_done   <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            polarity_inv <= pol_nx;
            left         <= left_nx;
            frame_done   <= done_nx;
            overflow     <= push && !accept;
            if (state != HUNT)  shreg <= '0;
            else if (bit_ev)    shreg <= shreg_nx;
            if (bit_ev && state != HUNT) bitcnt <= bitcnt + 3'd1;
            if (accept) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)    rd_ptr <= rd_ptr + PTR_ONE;
            case ({accept, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (bit_ev) acc <= acc_nx;
        if (accept) mem[wr_ptr] <= acc_nx;
    end

    assign byte_valid   = (count != '0);
    assign byte_out     = byte_valid ? mem[rd_ptr] : 8'h00;
    assign frame_active = (state != HUNT);
endmodule

// File: tb/tb_bpsk_frame_sync.sv
// Randomized bench for bpsk_frame_sync: a bit-level frame parser and queue-based FIFO
// reference predict every output each cycle; directed frames add end-to-end checks.
module tb_bpsk_frame_sync;
    localparam int DEPTH = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       bit_in = 1'b0;
    logic       bit_toggle = 1'b0;
    logic       byte_ready = 1'b0;
    logic [7:0] byte_out;
    logic       byte_valid, frame_active, polarity_inv, frame_done, overflow;

    bpsk_frame_sync #(.SYNC_BITS(16), .SYNC_WORD(16'hD391), .FIFO_DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .bit_in(bit_in), .bit_toggle(bit_toggle),
        .byte_out(byte_out), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .frame_active(frame_active), .polarity_inv(polarity_inv),
        .frame_done(frame_done), .overflow(overflow));

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference parser state (mode 0 = hunting, 1 = length, 2 = payload)
    int         m_mode = 0;
    logic [15:0] m_win = 16'h0;
    int         m_nb = 0;
    logic [7:0] m_acc = 8'h0;
    int         m_left = 0;
    bit         m_pol = 0;
    logic [7:0] mq[$];
    bit         e_done = 0, e_ovf = 0;

    int         rdy_mode = 1;
    logic [7:0] got[$];
    int         n_done, n_ovf, n_act;
    bit         pol_seen;
    bit         fb[$];

    task automatic to_hunt();
        m_mode = 0; m_pol = 0; m_win = 16'h0; m_nb = 0;
    endtask

    task automatic model_bit(input bit b, output int push_val, output bit done);
        bit e;
        push_val = -1;
        done = 0;
        e = b ^ m_pol;
        if (m_mode == 0) begin
            m_win = {m_win[14:0], b};
            if (m_win == 16'hD391) begin
                m_mode = 1; m_pol = 0; m_nb = 0;
            end else if (m_win == 16'h2C6E) begin
                m_mode = 1; m_pol = 1; m_nb = 0;
            end
        end else begin
            m_acc = {m_acc[6:0], e};
            m_nb++;
            if (m_nb == 8) begin
                m_nb = 0;
                if (m_mode == 1) begin
                    if (m_acc == 8'h00) begin
                        done = 1; to_hunt();
                    end else begin
                        m_left = m_acc; m_mode = 2;
                    end
                end else begin
                    push_val = m_acc;
                    m_left--;
                    if (m_left == 0) begin
                        done = 1; to_hunt();
                    end
                end
            end
        end
    endtask

    task automatic step(input bit ev, input bit b);
        int pv;
        bit dn;
        bit full;
        logic [7:0] eh;
        @(negedge clock);
        case (rdy_mode)
            0:       byte_ready = 1'b0;
            1:       byte_ready = 1'b1;
            default: byte_ready = 1'($urandom_range(0, 1));
        endcase
        pv = -1;
        dn = 0;
        if (ev) begin
            bit_in = b;
            bit_toggle = ~bit_toggle;
            model_bit(b, pv, dn);
        end else begin
            bit_in = 1'($urandom_range(0, 1));
        end
        #1;
        if (byte_valid && byte_ready) got.push_back(byte_out);
        full = (mq.size() >= DEPTH);
        e_ovf = 0;
        if (mq.size() > 0 && byte_ready) void'(mq.pop_front());
        if (pv >= 0) begin
            if (full) e_ovf = 1;
            else      mq.push_back(pv[7:0]);
        end
        e_done = dn;
        @(posedge clock);
        #1;
        eh = (mq.size() > 0) ? mq[0] : 8'h00;
        chk("byte_valid", 32'(byte_valid), 32'(mq.size() > 0));
        chk("byte_out", 32'(byte_out), 32'(eh));
        chk("frame_active", 32'(frame_active), 32'(m_mode != 0));
        chk("polarity_inv", 32'(polarity_inv), 32'(m_pol));
        chk("frame_done", 32'(frame_done), 32'(e_done));
        chk("overflow", 32'(overflow), 32'(e_ovf));
        n_done += int'(frame_done);
        n_ovf  += int'(overflow);
        n_act  += int'(frame_active);
        if (polarity_inv) pol_seen = 1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0);
    endtask

    task automatic send(input int gmin, input int gmax);
        foreach (fb[i]) begin
            repeat ($urandom_range(gmin, gmax)) step(0, 0);
            step(1, fb[i]);
        end
        fb.delete();
    endtask

    task automatic addv(input logic [15:0] v, input int nbits, input bit inv);
        for (int i = nbits - 1; i >= 0; i--) fb.push_back(v[i] ^ inv);
    endtask

    task automatic clr_logs();
        got.delete();
        n_done = 0; n_ovf = 0; n_act = 0; pol_seen = 0;
    endtask

    function automatic logic [31:0] gb(input int i);
        return (i < got.size()) ? {24'h0, got[i]} : 32'hFFFF_FFFF;
    endfunction

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        byte_ready = 1'b0;
        @(posedge clock);
        #1;
        chk("rst_byte_valid", 32'(byte_valid), 0);
        chk("rst_byte_out", 32'(byte_out), 0);
        chk("rst_frame_active", 32'(frame_active), 0);
        chk("rst_polarity_inv", 32'(polarity_inv), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_overflow", 32'(overflow), 0);
        to_hunt();
        mq.delete();
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        do_reset();

        // Basic frame, normal polarity
        clr_logs(); rdy_mode = 1;
        addv(16'hD391, 16, 0); addv(8'h02, 8, 0); addv(8'hA5, 8, 0); addv(8'h3C, 8, 0);
        send(3, 3); idle(10);
        chk("t1_count", got.size(), 2);
        chk("t1_b0", gb(0), 32'hA5);
        chk("t1_b1", gb(1), 32'h3C);
        chk("t1_done", n_done, 1);

        // Same frame fully inverted
        clr_logs();
        addv(16'hD391, 16, 1); addv(8'h02, 8, 1); addv(8'hA5, 8, 1); addv(8'h3C, 8, 1);
        send(3, 3); idle(10);
        chk("t2_pol_seen", 32'(pol_seen), 1);
        chk("t2_b0", gb(0), 32'hA5);
        chk("t2_b1", gb(1), 32'h3C);
        chk("t2_done", n_done, 1);

        // Backpressure: six bytes into a four-deep FIFO
        clr_logs(); rdy_mode = 0;
        addv(16'hD391, 16, 0); addv(8'h06, 8, 0);
        for (int i = 1; i <= 6; i++) addv(16'(i), 8, 0);
        send(1, 2); idle(5);
        chk("t3_ovf", n_ovf, 2);
        chk("t3_held_head", 32'(byte_out), 32'h01);
        chk("t3_none_popped", got.size(), 0);
        rdy_mode = 1; idle(8);
        chk("t3_count", got.size(), 4);
        for (int i = 0; i < 4; i++) chk("t3_byte", gb(i), 32'(i + 1));

        // Zero-length frame
        clr_logs();
        addv(16'hD391, 16, 0); addv(8'h00, 8, 0);
        send(3, 3); idle(6);
        chk("t4_done", n_done, 1);
        chk("t4_active_cycles", n_act, 32);
        chk("t4_no_bytes", got.size(), 0);

        // Reset after three payload bits, then a clean frame
        clr_logs();
        addv(16'hD391, 16, 0); addv(8'h02, 8, 0); addv(3'b101, 3, 0);
        send(1, 3);
        do_reset();
        chk("t5_no_done", n_done, 0);
        clr_logs();
        addv(16'hD391, 16, 0); addv(8'h02, 8, 0); addv(8'h5A, 8, 0); addv(8'hC3, 8, 0);
        send(0, 2); idle(8);
        chk("t5_b0", gb(0), 32'h5A);
        chk("t5_b1", gb(1), 32'hC3);
        chk("t5_done", n_done, 1);

        // Near-miss prefix, slow bits, random ready
        clr_logs(); rdy_mode = 2;
        addv(16'hD390, 16, 0); addv(16'hD391, 16, 0); addv(8'h03, 8, 0);
        addv(8'h81, 8, 0); addv(8'h7E, 8, 0); addv(8'h44, 8, 0);
        send(19, 19);
        rdy_mode = 1; idle(8);
        chk("t6_active_cycles", n_act, 640);
        chk("t6_done", n_done, 1);
        chk("t6_count", got.size(), 3);
        chk("t6_b0", gb(0), 32'h81);
        chk("t6_b1", gb(1), 32'h7E);
        chk("t6_b2", gb(2), 32'h44);

        // Random frames with noise, random polarity, gaps and backpressure
        rdy_mode = 2;
        for (int f = 0; f < 24; f++) begin
            bit inv;
            int len;
            inv = 1'($urandom_range(0, 1));
            len = $urandom_range(0, 6);
            addv(16'($urandom), $urandom_range(0, 12), 0);
            addv(16'hD391, 16, inv);
            addv(16'(len), 8, inv);
            for (int i = 0; i < len; i++) addv(16'($urandom), 8, inv);
            send(0, 3);
        end
        rdy_mode = 1; idle(12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
